// File: rtl/gl_decode.sv
// gl_decode: operand-gathering decode stage.
//
// Accepts one instruction word and its address from fetch. It reads the
// opcode's trailing operand words from a 1-cycle-latency BRAM port and packs
// them into one wide packet. The packet goes to execute under valid/ready.
// Fetch is stalled whenever the stage is not idle.
//
// Parameters
//   WIDTH     instruction / operand / address width
//   MAX_OPS   operand slots in the output packet
//   ADDR_STEP address increment between consecutive words
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous, active-low reset
//   inst_in       instruction word from fetch, opcode in [7:0]
//   inst_addr_in  address of inst_in
//   inst_valid    inst_in / inst_addr_in valid (sampled only when idle)
//   stall_out     stall to fetch, high whenever not idle (combinational)
//   bram_addr     operand BRAM read address (registered)
//   bram_data     operand BRAM read data, valid one cycle after its address
//   out_valid     packet valid
//   out_ready     execute accepts the packet (sampled only while emitting)
//   out_inst      full instruction word of the packet
//   out_count     number of operands in the packet
//   out_operands  operand k at [WIDTH*k +: WIDTH]
//
// Build option
//   GL_DECODE_OPERAND_CLEAR_EN  when defined, every operand slot is zeroed on
//                               accept, so unused slots read 0. Otherwise
//                               unused slots keep values from older packets.

module gl_decode #(
    parameter int WIDTH     = 32,
    parameter int MAX_OPS   = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         inst_in,
    input  logic [WIDTH-1:0]         inst_addr_in,
    input  logic                     inst_valid,
    output logic                     stall_out,
    output logic [WIDTH-1:0]         bram_addr,
    input  logic [WIDTH-1:0]         bram_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_inst,
    output logic [4:0]               out_count,
    output logic [WIDTH*MAX_OPS-1:0] out_operands
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(ADDR_STEP);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] issue_cnt;   // addresses issued for the current packet
    logic [4:0] cap_cnt;     // next operand slot to be captured
    logic       primed;      // first FETCH cycle done; bram_data now tracks bram_addr
    logic [4:0] dec_count;
    logic       accept;

    // Operand count per opcode.
    always_comb begin
        case (inst_in[7:0])
            8'h03, 8'h04:                      dec_count = 5'd3;
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18: dec_count = 5'd16;
            8'h19:                             dec_count = 5'd4;
            8'h1A:                             dec_count = 5'd6;
            default:                           dec_count = 5'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall_out  = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (inst_valid) begin
                    accept     = 1'b1;
                    state_next = (dec_count != 5'd0) ? FETCH : EMIT;
                end
            end
            FETCH: begin
                stall_out = 1'b1;
                // Leave once the last slot is being written on this edge.
                if (primed && (cap_cnt == out_count - 5'd1)) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                stall_out = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The address for operand 0 is issued on the accept edge, so the issue
    // counter starts at 1. Capture lags issue by one cycle, which the primed
    // flag accounts for.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bram_addr    <= '0;
            out_inst     <= '0;
            out_count    <= '0;
            out_operands <= '0;
            issue_cnt    <= '0;
            cap_cnt      <= '0;
            primed       <= 1'b0;
        end else if (accept) begin
            out_inst  <= inst_in;
            out_count <= dec_count;
            issue_cnt <= 5'd1;
            cap_cnt   <= '0;
            primed    <= 1'b0;
            if (dec_count != 5'd0) begin
                bram_addr <= inst_addr_in + STEP;
            end
`ifdef GL_DECODE_OPERAND_CLEAR_EN
            out_operands <= '0;
`else
            out_operands <= out_operands;
`endif
        end else if (state == FETCH) begin
            if (issue_cnt < out_count) begin
                bram_addr <= bram_addr + STEP;
                issue_cnt <= issue_cnt + 5'd1;
            end
            if (!primed) begin
                primed <= 1'b1;
            end else begin
                out_operands[int'(cap_cnt)*WIDTH +: WIDTH] <= bram_data;
                cap_cnt <= cap_cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_gl_decode.sv
`timescale 1ns/1ps
module tb_gl_decode;

    localparam int WIDTH   = 32;
    localparam int MAX_OPS = 16;
    localparam int STEP    = 4;
    localparam int SNAP_W  = WIDTH + 5 + WIDTH*MAX_OPS;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [WIDTH-1:0]         inst_in;
    logic [WIDTH-1:0]         inst_addr_in;
    logic                     inst_valid;
    logic                     stall_out;
    logic [WIDTH-1:0]         bram_addr;
    logic [WIDTH-1:0]         bram_data = '0;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_inst;
    logic [4:0]               out_count;
    logic [WIDTH*MAX_OPS-1:0] out_operands;

    always #5 clk = ~clk;

    gl_decode #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS), .ADDR_STEP(STEP)) dut (
        .clk(clk), .reset(reset), .inst_in(inst_in), .inst_addr_in(inst_addr_in),
        .inst_valid(inst_valid), .stall_out(stall_out), .bram_addr(bram_addr),
        .bram_data(bram_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_count(out_count), .out_operands(out_operands)
    );

    // Operand memory: explicit words, everything else derived from the address.
    logic [31:0] mem [bit [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) bram_data <= mem_rd(bram_addr);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int op_count(input logic [7:0] op);
        case (op)
            8'h03, 8'h04:                      return 3;
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18: return 16;
            8'h19:                             return 4;
            8'h1A:                             return 6;
            default:                           return 0;
        endcase
    endfunction

    // Packet visible this many edges after the accept edge.
    function automatic int valid_age(input int n);
        return (n == 0) ? 0 : n + 1;
    endfunction

    // Transaction-level model: age counts edges since accept.
    logic        m_busy;
    int          m_age;
    int          m_n;
    logic [31:0] m_base;
    logic [31:0] m_baddr;
    logic [31:0] m_inst;
    logic [4:0]  m_count;
    logic [31:0] m_ops [MAX_OPS];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy  <= 1'b0;
            m_age   <= 0;
            m_n     <= 0;
            m_base  <= '0;
            m_baddr <= '0;
            m_inst  <= '0;
            m_count <= '0;
            for (int k = 0; k < MAX_OPS; k++) m_ops[k] <= '0;
        end else if (m_busy) begin
            if (m_age >= valid_age(m_n) && out_ready) begin
                m_busy <= 1'b0;
            end else begin
                m_age <= m_age + 1;
                if (m_age + 1 < m_n) m_baddr <= m_base + 32'(STEP*(m_age+1));
            end
        end else if (inst_valid) begin
            m_busy  <= 1'b1;
            m_age   <= 0;
            m_n     <= op_count(inst_in[7:0]);
            m_inst  <= inst_in;
            m_count <= 5'(op_count(inst_in[7:0]));
            m_base  <= inst_addr_in + 32'(STEP);
            if (op_count(inst_in[7:0]) > 0) m_baddr <= inst_addr_in + 32'(STEP);
            for (int k = 0; k < MAX_OPS; k++) begin
                if (k < op_count(inst_in[7:0]))
                    m_ops[k] <= mem_rd(inst_addr_in + 32'(STEP*(k+1)));
`ifdef GL_DECODE_OPERAND_CLEAR_EN
                else
                    m_ops[k] <= '0;
`endif
            end
        end
    end

    logic cmp_en = 1'b0;

    always @(negedge clk) begin : compare
        logic mv;
        if (cmp_en) begin
            mv = m_busy && (m_age >= valid_age(m_n));
            check("m_valid", {31'b0, out_valid}, {31'b0, mv});
            check("m_stall", {31'b0, stall_out}, {31'b0, m_busy});
            check("m_bram_addr", bram_addr, m_baddr);
            check("m_inst", out_inst, m_inst);
            check("m_count", {27'b0, out_count}, {27'b0, m_count});
            if (mv) begin
                for (int k = 0; k < MAX_OPS; k++)
                    check($sformatf("m_op%0d", k), out_operands[WIDTH*k +: WIDTH], m_ops[k]);
            end
        end
    end

    logic [31:0]              seq [3];
    logic [WIDTH*MAX_OPS-1:0] v_ops;
    logic [4:0]               v_count;
    logic [31:0]              v_inst;
    int                       rise;
    int                       stalls;

    function automatic logic [31:0] slot(input logic [WIDTH*MAX_OPS-1:0] ops, input int k);
        return ops[WIDTH*k +: WIDTH];
    endfunction

    // Issue one instruction from idle, hold out_ready low for `hold` cycles
    // once the packet is valid, then hand it off.
    task automatic run_inst(input logic [31:0] inst, input logic [31:0] addr, input int hold);
        int c;
        logic [SNAP_W-1:0] snap;
        inst_in      = inst;
        inst_addr_in = addr;
        inst_valid   = 1'b1;
        out_ready    = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
        c      = 0;
        stalls = 0;
        for (int s = 0; s < 3; s++) seq[s] = 'x;
        while (!out_valid && c < 40) begin
            if (c < 3) seq[c] = bram_addr;
            if (stall_out) stalls++;
            @(negedge clk);
            c++;
        end
        check("valid_seen", {31'b0, out_valid}, 1);
        if (stall_out) stalls++;
        rise    = c;
        v_inst  = out_inst;
        v_count = out_count;
        v_ops   = out_operands;
        snap    = {out_inst, out_count, out_operands};
        for (int d = 0; d < hold; d++) begin
            @(negedge clk);
            if (stall_out) stalls++;
            check("hold_stable", {31'b0, snap == {out_inst, out_count, out_operands}}, 1);
            check("hold_valid", {31'b0, out_valid}, 1);
            check("hold_stall", {31'b0, stall_out}, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("handoff_valid", {31'b0, out_valid}, 0);
        check("handoff_stall", {31'b0, stall_out}, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] misc_ops [5];
        reset        = 1'b0;
        inst_valid   = 1'b0;
        inst_in      = '0;
        inst_addr_in = '0;
        out_ready    = 1'b0;
        mem[32'h104] = 32'hA;
        mem[32'h108] = 32'hB;
        mem[32'h10C] = 32'hC;
        for (int k = 0; k < 16; k++) mem[32'(4*(k+1))] = 32'(k+1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_stall", {31'b0, stall_out}, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_count", {27'b0, out_count}, 0);
        check("rst_inst", out_inst, 0);
        check("rst_ops", {31'b0, out_operands == '0}, 1);
        reset = 1'b1;
        @(negedge clk);

        // VERTEX at 0x100
        run_inst(32'hABCD_0003, 32'h100, 0);
        check("vtx_rise", rise, 4);
        check("vtx_addr0", seq[0], 32'h104);
        check("vtx_addr1", seq[1], 32'h108);
        check("vtx_addr2", seq[2], 32'h10C);
        check("vtx_count", {27'b0, v_count}, 3);
        check("vtx_inst", v_inst, 32'hABCD_0003);
        check("vtx_op0", slot(v_ops, 0), 32'hA);
        check("vtx_op1", slot(v_ops, 1), 32'hB);
        check("vtx_op2", slot(v_ops, 2), 32'hC);

        // Zero-operand opcode right after the VERTEX
        run_inst(32'h55AA_0001, 32'h300, 0);
        check("nop_rise", rise, 0);
        check("nop_count", {27'b0, v_count}, 0);
        check("nop_inst", v_inst, 32'h55AA_0001);
`ifdef GL_DECODE_OPERAND_CLEAR_EN
        check("nop_op0", slot(v_ops, 0), 32'h0);
        check("nop_op1", slot(v_ops, 1), 32'h0);
        check("nop_op2", slot(v_ops, 2), 32'h0);
`else
        check("nop_op0", slot(v_ops, 0), 32'hA);
        check("nop_op1", slot(v_ops, 1), 32'hB);
        check("nop_op2", slot(v_ops, 2), 32'hC);
`endif

        // LOADMATRIX at 0x0, out_ready high throughout
        run_inst(32'h0000_0013, 32'h0, 0);
        check("lm_rise", rise, 17);
        check("lm_stall_cycles", stalls, 18);
        check("lm_count", {27'b0, v_count}, 16);
        check("lm_op0", slot(v_ops, 0), 32'd1);
        check("lm_op7", slot(v_ops, 7), 32'd8);
        check("lm_op15", slot(v_ops, 15), 32'd16);

        // FRUSTUM with 5 cycles of back-pressure
        run_inst(32'h0000_001A, 32'h400, 5);
        check("fr_rise", rise, 7);
        check("fr_count", {27'b0, v_count}, 6);
        check("fr_op0", slot(v_ops, 0), 32'h5A5A_0404);
        check("fr_op5", slot(v_ops, 5), 32'h5A5A_0418);

        // COLOR with address wrap
        run_inst(32'h0000_0004, 32'hFFFF_FFF8, 0);
        check("wrap_addr0", seq[0], 32'hFFFF_FFFC);
        check("wrap_addr1", seq[1], 32'h0000_0000);
        check("wrap_addr2", seq[2], 32'h0000_0004);
        check("wrap_op2", slot(v_ops, 2), 32'd1);

        // Asynchronous reset in the middle of a MULTMATRIX fetch
        inst_in      = 32'h0000_0011;
        inst_addr_in = 32'h200;
        inst_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mm_busy", {31'b0, stall_out}, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 0);
        check("mid_rst_stall", {31'b0, stall_out}, 0);
        check("mid_rst_bram_addr", bram_addr, 0);
        check("mid_rst_count", {27'b0, out_count}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_inst(32'h1234_0003, 32'h100, 0);
        check("post_rst_rise", rise, 4);
        check("post_rst_count", {27'b0, v_count}, 3);
        check("post_rst_op1", slot(v_ops, 1), 32'hB);

        // Remaining opcodes, checked by the model
        misc_ops[0] = 8'h16;
        misc_ops[1] = 8'h17;
        misc_ops[2] = 8'h18;
        misc_ops[3] = 8'h19;
        misc_ops[4] = 8'hFF;
        for (int t = 0; t < 5; t++) begin
            run_inst({24'h00C0DE, misc_ops[t]}, 32'(32'h1000 * (t+1)), t % 2);
        end
        check("vp_count", {27'b0, v_count}, 0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gl_decode.md
# gl_decode

Operand-gathering decode stage directly downstream of the instruction fetch stage. It accepts one instruction word plus its address, reads the instruction's trailing operand words from the operand BRAM port, packs them into a single wide packet, and presents that packet to the execute stage with a valid/ready handshake. While it is busy, it back-pressures fetch through `stall_out`.

## Interface
- `WIDTH`, 32: instruction, operand and address width.
- `MAX_OPS`, 16: operand slots in the output packet.
- `ADDR_STEP`, 4: address increment between consecutive words.

- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inst_in`  in  WIDTH  instruction word from fetch; opcode in [7:0].
- `inst_addr_in`  in  WIDTH  address of `inst_in`.
- `inst_valid`  in  1  `inst_in`/`inst_addr_in` are valid this cycle.
- `stall_out`  out  1  to fetch stall; combinational, high whenever state != IDLE.
- `bram_addr`  out  WIDTH  operand BRAM read address, registered.
- `bram_data`  in  WIDTH  operand BRAM read data, valid one cycle after its address.
- `out_valid`  out  1  packet valid.
- `out_ready`  in  1  execute accepts the packet.
- `out_inst`  out  WIDTH  full instruction word.
- `out_count`  out  5  operand count, 0..16.
- `out_operands`  out  WIDTH*MAX_OPS  operand k at bits [WIDTH*k+WIDTH-1 : WIDTH*k].

## Operation
- Operand count per opcode:
  - 8'h03 VERTEX: 3
  - 8'h04 COLOR: 3
  - 8'h11 MULTMATRIX, 8'h13 LOADMATRIX, 8'h16 ROTATE, 8'h17 SCALE, 8'h18 TRANSLATE: 16
  - 8'h19 VIEWPORT: 4
  - 8'h1A FRUSTUM: 6
  - all other opcodes: 0
- Operand k (0-based) is read from `inst_addr_in + ADDR_STEP*(k+1)`. Addresses are WIDTH-bit and wrap modulo 2^WIDTH.
- State IDLE:
  - When `inst_valid` is high, latch `out_inst`, `out_count` and base = `inst_addr_in + ADDR_STEP`.
  - If the count is greater than 0, load `bram_addr` with base and go to FETCH; otherwise go to EMIT.
  - When `inst_valid` is low, stay in IDLE.
- State FETCH:
  - Issue counter i (address issue) and capture counter j (data capture).
  - Each cycle while i < count: advance `bram_addr` by ADDR_STEP and increment i.
  - Each cycle after the first FETCH cycle: write `bram_data` into slot j and increment j.
  - When the last slot (j = count-1) is written, go to EMIT.
- State EMIT:
  - `out_valid` = 1. All outputs are held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
  - An instruction is never accepted in the same cycle as packet handoff.
- `out_inst`, `out_count` and `out_operands` are registers and change only on accept or capture.
- Reset (asynchronous, also mid-FETCH or mid-EMIT):
  - state = IDLE; i = j = 0.
  - `out_valid` = 0, `bram_addr` = 0, `out_inst` = 0, `out_count` = 0, `out_operands` = 0.
  - `stall_out` = 0, since it follows the state.
  - Any in-flight packet is discarded.

## Timing
- Accept edge E0: the first edge on which IDLE and `inst_valid` are both high.
- N = 0: `out_valid` is high from E0 to E1. Minimum 2 cycles per instruction.
- N > 0:
  - FETCH occupies N+1 cycles.
  - `out_valid` rises after edge E0+N+1.
  - Best-case period is N+3 cycles.
- `stall_out` is high from after E0 until the handoff edge. Fetch therefore holds its next instruction, which it captured at E0.
- `out_ready` is ignored outside EMIT.
- `inst_valid` is ignored outside IDLE.
- BRAM read latency is fixed at 1 cycle. No other BRAM handshake exists.

## Configuration
- `GL_DECODE_OPERAND_CLEAR_EN`
  - Defined: on accept, all MAX_OPS slots of `out_operands` are cleared to 0. Slots at index ≥ `out_count` read 0 in EMIT.
  - Undefined: unused slots retain their values from earlier packets. This saves the clear logic.

## Test plan
- Reset: assert `reset`=0 mid-FETCH of a MULTMATRIX -> `out_valid`=0, `stall_out`=0, `bram_addr`=0 immediately. After release, the next instruction decodes normally.
- VERTEX at address 0x100, BRAM[0x104/0x108/0x10C] = 0xA/0xB/0xC:
  - `bram_addr` sequence is 0x104, 0x108, 0x10C.
  - `out_valid` rises 4 edges after accept, with count 3 and operands {0xA, 0xB, 0xC}.
- LOADMATRIX at 0x0 with BRAM[4(k+1)] = k+1 -> count 16, slot k = k+1. `stall_out` is high for exactly 18 cycles with `out_ready` tied high.
- Back-pressure: FRUSTUM with `out_ready`=0 for 5 cycles -> `out_valid` and all outputs stay constant and `stall_out` stays high. Handoff occurs on the first edge with `out_ready`=1.
- Opcode 8'h01 after a VERTEX -> count 0, packet valid 1 cycle after accept.
  - With `GL_DECODE_OPERAND_CLEAR_EN` defined, slots 0-2 read 0.
  - Without it, slots 0-2 still read 0xA/0xB/0xC.
- Address wrap: COLOR at 0xFFFFFFF8 -> `bram_addr` sequence is 0xFFFFFFFC, 0x00000000, 0x00000004.
